csr_hpm_unit: RTL

Parametrised machine-mode CSR file, successor to the single-hart CSR block. Adds set/clear write ops, mcountinhibit, NUM_HPM programmable hardware performance counters with event selectors, and prioritised interrupt-request generation from mip/mie. Also adds interrupt-aware vectored trap targets. Sits beside the execute stage: the core reads and writes CSRs, reports traps and mret, and receives registered redirect pulses.

---
 rtl/csr_hpm_unit.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/csr_hpm_unit.sv
// Machine-mode CSR file: set/clear ops, mcountinhibit, NUM_HPM perf counters, prioritised IRQ request, vectored trap target.
// Latency: reads/illegal/irq combinational; CSR writes, counters, trap/mret effects land on the next edge; pulses registered (1 cycle).
// Backpressure: none; every write, trap and mret is accepted in the cycle it is presented.
// Ports: i_rden/i_raddr -> o_rdata/o_illegal; i_wop/i_waddr/i_wdata write port; i_retire/i_events count sources;
//        i_irq_* -> o_irq_req/o_irq_cause; i_trap_*/i_mret_in -> o_trap_pulse/o_mret_pulse, o_mepc_out/o_tvec_out.
module csr_hpm_unit #(
  parameter int          NUM_HPM     = 4,
  parameter int          NUM_EVENTS  = 8,
  parameter logic [31:0] MISA_VAL    = 32'h40001104,
  parameter logic [31:0] RESET_MTVEC = 32'h0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rden,
  input  logic [11:0]           i_raddr,
  output logic [31:0]           o_rdata,
  output logic                  o_illegal,
  input  logic [1:0]            i_wop,
  input  logic [11:0]           i_waddr,
  input  logic [31:0]           i_wdata,
  input  logic                  i_retire,
  input  logic [NUM_EVENTS-1:0] i_events,
  input  logic                  i_irq_ext,
  input  logic                  i_irq_tim,
  input  logic                  i_irq_sw,
  output logic                  o_irq_req,
  output logic [3:0]            o_irq_cause,
  input  logic                  i_trap_valid,
  input  logic                  i_trap_int,
  input  logic [3:0]            i_trap_cause,
  input  logic [31:0]           i_trap_epc,
  input  logic [31:0]           i_trap_tval,
  input  logic                  i_mret_in,
  output logic                  o_trap_pulse,
  output logic                  o_mret_pulse,
  output logic [31:0]           o_mepc_out,
  output logic [31:0]           o_tvec_out
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MCNTINH  = 12'h320;
  localparam logic [11:0] A_HPMEVT   = 12'h323;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_HPMCNT   = 12'hB03;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;
  localparam logic [11:0] A_HPMCNTH  = 12'hB83;

  logic        r_mstatus_mie, r_mstatus_mpie;
  logic [31:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval, r_mcntinh;
  logic        r_mip_e, r_mip_t, r_mip_s;
  logic [63:0] r_mcycle, r_minstret;
  logic [63:0] r_hpm_cnt [NUM_HPM];
  logic [31:0] r_hpm_evt [NUM_HPM];
  logic        r_trap_pulse, r_mret_pulse;

  logic [31:0] w_mstatus, w_mip, w_wval;
  logic [32:0] w_rd, w_wr;
  logic        w_wen;
  logic [2:0]  w_pend;
  logic [NUM_HPM-1:0] w_hpm_inc;
  logic [63:0] w_mcycle_nxt, w_minstret_nxt;
  logic [63:0] w_hpm_nxt [NUM_HPM];

  // MPP is hardwired to machine mode, so it always reads 11.
  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
  assign w_mip     = {20'b0, r_mip_e, 3'b0, r_mip_t, 3'b0, r_mip_s, 3'b0};

  // {implemented, value} for one CSR address.
  function automatic logic [32:0] csr_lookup(input logic [11:0] a);
    logic [32:0] r;
    r = '0;
    case (a)
      A_MSTATUS:  r = {1'b1, w_mstatus};
      A_MISA:     r = {1'b1, MISA_VAL};
      A_MIE:      r = {1'b1, r_mie};
      A_MTVEC:    r = {1'b1, r_mtvec};
      A_MCNTINH:  r = {1'b1, r_mcntinh};
      A_MSCRATCH: r = {1'b1, r_mscratch};
      A_MEPC:     r = {1'b1, r_mepc};
      A_MCAUSE:   r = {1'b1, r_mcause};
      A_MTVAL:    r = {1'b1, r_mtval};
      A_MIP:      r = {1'b1, w_mip};
      A_MCYCLE:   r = {1'b1, r_mcycle[31:0]};
      A_MCYCLEH:  r = {1'b1, r_mcycle[63:32]};
      A_MINSTRET: r = {1'b1, r_minstret[31:0]};
      A_MINSTRH:  r = {1'b1, r_minstret[63:32]};
      default:    r = '0;
    endcase
    for (int k = 0; k < NUM_HPM; k++) begin
      if (a == 12'(A_HPMEVT + k)) r = {1'b1, r_hpm_evt[k]};
      if (a == 12'(A_HPMCNT + k)) r = {1'b1, r_hpm_cnt[k][31:0]};
      if (a == 12'(A_HPMCNTH + k)) r = {1'b1, r_hpm_cnt[k][63:32]};
    end
    return r;
  endfunction

  // Writing the low half holds the high half (carry dropped); writing the
  // high half lets the low half keep counting but discards its carry.
  function automatic logic [63:0] cnt_next(input logic [63:0] c, input logic inc,
                                           input logic lo_wr, input logic hi_wr,
                                           input logic [31:0] v);
    logic [63:0] s, n;
    s = c + {63'b0, inc};
    n[31:0]  = lo_wr ? v : s[31:0];
    n[63:32] = hi_wr ? v : (lo_wr ? c[63:32] : s[63:32]);
    return n;
  endfunction

  always_comb begin
    w_rd   = csr_lookup(i_raddr);
    w_wr   = csr_lookup(i_waddr);
    w_wen  = (i_wop != 2'b00) && w_wr[32];
    case (i_wop)
      2'b10:   w_wval = w_wr[31:0] | i_wdata;
      2'b11:   w_wval = w_wr[31:0] & ~i_wdata;
      default: w_wval = i_wdata;
    endcase
  end

  assign o_rdata   = (i_rden && w_rd[32]) ? w_rd[31:0] : 32'h0;
  assign o_illegal = i_rden && !w_rd[32];

  // Selector value s counts events[s-1]; 0 or anything above NUM_EVENTS never matches.
  always_comb begin
    w_hpm_inc = '0;
    for (int k = 0; k < NUM_HPM; k++) begin
      for (int e = 0; e < NUM_EVENTS; e++) begin
        if (r_hpm_evt[k] == 32'(e + 1) && i_events[e] && !r_mcntinh[3 + k]) w_hpm_inc[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_mcycle_nxt   = cnt_next(r_mcycle, !r_mcntinh[0], w_wen && i_waddr == A_MCYCLE,
                              w_wen && i_waddr == A_MCYCLEH, w_wval);
    w_minstret_nxt = cnt_next(r_minstret, i_retire && !r_mcntinh[2], w_wen && i_waddr == A_MINSTRET,
                              w_wen && i_waddr == A_MINSTRH, w_wval);
    for (int k = 0; k < NUM_HPM; k++) begin
      w_hpm_nxt[k] = cnt_next(r_hpm_cnt[k], w_hpm_inc[k], w_wen && i_waddr == 12'(A_HPMCNT + k),
                              w_wen && i_waddr == 12'(A_HPMCNTH + k), w_wval);
    end
  end

  // Pending bits in priority-relevant order: {MEI, MTI, MSI}.
  assign w_pend    = {r_mip_e & r_mie[11], r_mip_t & r_mie[7], r_mip_s & r_mie[3]};
  assign o_irq_req = r_mstatus_mie && (w_pend != 3'b000);

  always_comb begin
    o_irq_cause = 4'd0;
    if (w_pend[2])      o_irq_cause = 4'd11;
    else if (w_pend[0]) o_irq_cause = 4'd3;
    else if (w_pend[1]) o_irq_cause = 4'd7;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= RESET_MTVEC;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
      r_mcntinh      <= '0;
      r_mip_e        <= 1'b0;
      r_mip_t        <= 1'b0;
      r_mip_s        <= 1'b0;
      r_mcycle       <= '0;
      r_minstret     <= '0;
      for (int k = 0; k < NUM_HPM; k++) begin
        r_hpm_cnt[k] <= '0;
        r_hpm_evt[k] <= '0;
      end
      r_trap_pulse   <= 1'b0;
      r_mret_pulse   <= 1'b0;
    end else begin
      r_mip_e <= i_irq_ext;
      r_mip_t <= i_irq_tim;
      r_mip_s <= i_irq_sw;
      if (w_wen && i_waddr == A_MIE)      r_mie      <= w_wval;
      if (w_wen && i_waddr == A_MSCRATCH) r_mscratch <= w_wval;
      if (w_wen && i_waddr == A_MCNTINH)  r_mcntinh  <= w_wval & ~32'h2;
      // Reserved modes 2/3 collapse to direct mode.
      if (w_wen && i_waddr == A_MTVEC)
        r_mtvec <= {w_wval[31:2], (w_wval[1:0] == 2'b01) ? 2'b01 : 2'b00};
      for (int k = 0; k < NUM_HPM; k++) begin
        if (w_wen && i_waddr == 12'(A_HPMEVT + k)) r_hpm_evt[k] <= w_wval;
        r_hpm_cnt[k] <= w_hpm_nxt[k];
      end
      r_mcycle   <= w_mcycle_nxt;
      r_minstret <= w_minstret_nxt;
      // Trap owns mstatus/mepc/mcause/mtval over both mret and CSR writes.
      if (i_trap_valid) begin
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
        r_mepc         <= {i_trap_epc[31:1], 1'b0};
        r_mcause       <= {i_trap_int, 27'b0, i_trap_cause};
        r_mtval        <= i_trap_int ? 32'h0 : i_trap_tval;
      end else begin
        if (i_mret_in) begin
          r_mstatus_mie  <= r_mstatus_mpie;
          r_mstatus_mpie <= 1'b1;
        end else if (w_wen && i_waddr == A_MSTATUS) begin
          r_mstatus_mie  <= w_wval[3];
          r_mstatus_mpie <= w_wval[7];
        end
        if (w_wen && i_waddr == A_MEPC)   r_mepc   <= {w_wval[31:1], 1'b0};
        if (w_wen && i_waddr == A_MCAUSE) r_mcause <= w_wval;
        if (w_wen && i_waddr == A_MTVAL)  r_mtval  <= w_wval;
      end
      r_trap_pulse <= i_trap_valid;
      r_mret_pulse <= i_mret_in && !i_trap_valid;
    end
  end

  assign o_trap_pulse = r_trap_pulse;
  assign o_mret_pulse = r_mret_pulse;
  assign o_mepc_out   = r_mepc;
  // Vectored target uses the registered mcause so it lines up with trap_pulse.
  assign o_tvec_out   = (r_mtvec[1:0] == 2'b01 && r_mcause[31]) ?
                        {r_mtvec[31:2] + {26'b0, r_mcause[3:0]}, 2'b00} :
                        {r_mtvec[31:2], 2'b00};

endmodule
